gpu_cmd_sequencer: RTL and testbench

Sits between the host command FIFO and the GPU back end. It pops 32-bit command words from a show-ahead FIFO and decodes the opcodes. Draw-triangle commands are assembled into a single parallel descriptor and handed to the rasterizer over a valid/ready handshake. End-of-frame commands are sequenced by starting the framebuffer flush engine, which writes to SDRAM, and waiting for it to complete.

---
 rtl/gpu_cmd_sequencer_if.sv | 30 +++
 rtl/gpu_cmd_sequencer.sv | 145 ++++++++++++++
 tb/tb_gpu_cmd_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_cmd_sequencer_if.sv
// Command-path bundle between the sequencer, the host command FIFO,
// the rasterizer descriptor port and the framebuffer flush engine.
interface gpu_cmd_sequencer_if;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_read;
  logic        tri_valid;
  logic        tri_ready;
  logic [7:0]  tri_tex;
  logic [15:0] tri_x1;
  logic [15:0] tri_y1;
  logic [15:0] tri_x2;
  logic [15:0] tri_y2;
  logic [15:0] tri_x3;
  logic [15:0] tri_y3;
  logic        flush_start;
  logic        flush_done;

  modport master (
    input  fifo_rdata, fifo_empty, tri_ready, flush_done,
    output fifo_read, tri_valid, tri_tex,
           tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, flush_start
  );

  modport slave (
    output fifo_rdata, fifo_empty, tri_ready, flush_done,
    input  fifo_read, tri_valid, tri_tex,
           tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3, flush_start
  );
endinterface

// File: rtl/gpu_cmd_sequencer.sv
// Pops command words from a show-ahead FIFO, assembles draw-triangle descriptors
// for the rasterizer and sequences end-of-frame flushes.
module gpu_cmd_sequencer #(
  parameter int unsigned NUM_TEX = 8,
  parameter int unsigned FRAME_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  gpu_cmd_sequencer_if.master bus,
  output logic [FRAME_W-1:0] frame_count,
  output logic               busy,
  output logic               err_illegal
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned TEX_W  = 8;
  localparam int unsigned CRD_W  = 16;
  localparam logic [3:0]  OP_NOP  = 4'd0;
  localparam logic [3:0]  OP_DRAW = 4'd1;
  localparam logic [3:0]  OP_EOF  = 4'd2;

  typedef enum logic [2:0] {
    HDR, V1, V2, V3, ISSUE, FLUSH, WAIT_FLUSH
  } state_e;

  state_e                     state_q, state_d;
  logic [TEX_W-1:0]           tex_q, tex_d;
  logic [2:0][WORD_W-1:0]     vtx_q, vtx_d;
  logic [FRAME_W-1:0]         frame_q, frame_d;
  logic                       err_q, err_d;
  logic                       tri_valid_q, tri_valid_d;
  logic                       flush_start_q, flush_start_d;
  logic                       busy_q, busy_d;
  logic                       fifo_read_c;
  logic                       tex_ok_c;
  logic [3:0]                 op_c;

  assign op_c     = bus.fifo_rdata[31:28];
  assign tex_ok_c = (32'(tex_q) < NUM_TEX);

  // Next-state, datapath capture and pop strobe
  always_comb begin
    state_d     = state_q;
    tex_d       = tex_q;
    vtx_d       = vtx_q;
    frame_d     = frame_q;
    err_d       = err_q;
    fifo_read_c = 1'b0;
    unique case (state_q)
      HDR: begin
        if (!bus.fifo_empty) begin
          fifo_read_c = 1'b1;
          unique case (op_c)
            OP_NOP:  state_d = HDR;
            OP_DRAW: begin
              tex_d   = bus.fifo_rdata[TEX_W-1:0];
              state_d = V1;
            end
            OP_EOF:  state_d = FLUSH;
            default: err_d = 1'b1;
          endcase
        end
      end
      V1: begin
        if (!bus.fifo_empty) begin
          fifo_read_c = 1'b1;
          vtx_d[0]    = bus.fifo_rdata;
          state_d     = V2;
        end
      end
      V2: begin
        if (!bus.fifo_empty) begin
          fifo_read_c = 1'b1;
          vtx_d[1]    = bus.fifo_rdata;
          state_d     = V3;
        end
      end
      V3: begin
        // Bad texture still consumes all three vertices to keep the stream aligned
        if (!bus.fifo_empty) begin
          fifo_read_c = 1'b1;
          vtx_d[2]    = bus.fifo_rdata;
          if (tex_ok_c) begin
            state_d = ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = HDR;
          end
        end
      end
      ISSUE: begin
        if (bus.tri_ready) state_d = HDR;
      end
      FLUSH: state_d = WAIT_FLUSH;
      WAIT_FLUSH: begin
        if (bus.flush_done) begin
          frame_d = frame_q + FRAME_W'(1);
          state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
    if (reset) fifo_read_c = 1'b0;
    tri_valid_d   = (state_d == ISSUE);
    flush_start_d = (state_d == FLUSH);
    busy_d        = (state_d != HDR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HDR;
      tex_q         <= '0;
      vtx_q         <= '0;
      frame_q       <= '0;
      err_q         <= 1'b0;
      tri_valid_q   <= 1'b0;
      flush_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tex_q         <= tex_d;
      vtx_q         <= vtx_d;
      frame_q       <= frame_d;
      err_q         <= err_d;
      tri_valid_q   <= tri_valid_d;
      flush_start_q <= flush_start_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.fifo_read   = fifo_read_c;
  assign bus.tri_valid   = tri_valid_q;
  assign bus.tri_tex     = tex_q;
  assign bus.tri_x1      = vtx_q[0][WORD_W-1:CRD_W];
  assign bus.tri_y1      = vtx_q[0][CRD_W-1:0];
  assign bus.tri_x2      = vtx_q[1][WORD_W-1:CRD_W];
  assign bus.tri_y2      = vtx_q[1][CRD_W-1:0];
  assign bus.tri_x3      = vtx_q[2][WORD_W-1:CRD_W];
  assign bus.tri_y3      = vtx_q[2][CRD_W-1:0];
  assign bus.flush_start = flush_start_q;
  assign frame_count     = frame_q;
  assign busy            = busy_q;
  assign err_illegal     = err_q;

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Directed bench for gpu_cmd_sequencer: table of draw commands plus hand-written
// stall, backpressure, flush, illegal-command, reset and counter-wrap sequences.
module tb_gpu_cmd_sequencer;

  typedef struct {
    logic [31:0] hdr, w1, w2, w3;
    logic        exp_valid;
    logic [7:0]  exp_tex;
    logic [15:0] ex1, ey1, ex2, ey2, ex3, ey3;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpu_cmd_sequencer_if bus();
  logic [15:0] frame_count;
  logic        busy, err_illegal;

  gpu_cmd_sequencer #(.NUM_TEX(8), .FRAME_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .frame_count(frame_count), .busy(busy), .err_illegal(err_illegal)
  );

  // Narrow-counter instance fed an endless stream of end-of-frame commands
  gpu_cmd_sequencer_if wbus();
  logic [1:0] w_frame;
  logic       w_busy, w_err, w_en;

  gpu_cmd_sequencer #(.NUM_TEX(8), .FRAME_W(2)) dut_w (
    .clk(clk), .reset(reset), .bus(wbus),
    .frame_count(w_frame), .busy(w_busy), .err_illegal(w_err)
  );
  assign wbus.fifo_rdata = 32'h2000_0000;
  assign wbus.fifo_empty = ~w_en;
  assign wbus.tri_ready  = 1'b1;
  assign wbus.flush_done = 1'b1;

  logic [31:0] q[$];
  logic        stall;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  vec_t        vt[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty = stall || (q.size() == 0);
    bus.fifo_rdata = (q.size() != 0) ? q[0] : 32'h0;
  endtask

  task automatic settle();
    drive_fifo();
    #1;
  endtask

  // Advance one clock; a pop seen before the edge removes the FIFO head
  task automatic cycle();
    logic p;
    p = bus.fifo_read;
    @(posedge clk);
    #1;
    if (p && q.size() != 0) void'(q.pop_front());
    drive_fifo();
    @(negedge clk);
    #1;
  endtask

  task automatic push_vec(input vec_t c);
    q.push_back(c.hdr); q.push_back(c.w1); q.push_back(c.w2); q.push_back(c.w3);
  endtask

  task automatic check_tri(input vec_t c, input string tag);
    check({tag, " valid"}, bus.tri_valid, 1'b1);
    check({tag, " tex"},   bus.tri_tex,   c.exp_tex);
    check({tag, " x1"},    bus.tri_x1,    c.ex1);
    check({tag, " y1"},    bus.tri_y1,    c.ey1);
    check({tag, " x2"},    bus.tri_x2,    c.ex2);
    check({tag, " y2"},    bus.tri_y2,    c.ey2);
    check({tag, " x3"},    bus.tri_x3,    c.ex3);
    check({tag, " y3"},    bus.tri_y3,    c.ey3);
  endtask

  task automatic pop4(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s pop%0d", tag, i), bus.fifo_read, 1'b1);
      check($sformatf("%s novalid%0d", tag, i), bus.tri_valid, 1'b0);
      cycle();
    end
  endtask

  // Expects to start in HDR with the command at the FIFO head and tri_ready=1
  task automatic run_draw(input vec_t c, input string tag);
    pop4(tag);
    if (c.exp_valid) begin
      check_tri(c, tag);
      check({tag, " busy"}, busy, 1'b1);
      cycle();
      check({tag, " drop"}, bus.tri_valid, 1'b0);
      check({tag, " idle"}, busy, 1'b0);
    end else begin
      check({tag, " noissue"}, bus.tri_valid, 1'b0);
      check({tag, " idle"}, busy, 1'b0);
      check({tag, " err"}, err_illegal, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vs, vb;
    vt[0] = '{32'h1000_0001, 32'h000A_000A, 32'h000A_006E, 32'h006E_000A, 1'b1, 8'd1,
              16'd10, 16'd10, 16'd10, 16'd110, 16'd110, 16'd10};
    vt[1] = '{32'h1ABC_DE07, 32'hFFFF_0000, 32'h0000_FFFF, 32'h1234_5678, 1'b1, 8'd7,
              16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 16'h1234, 16'h5678};
    vt[2] = '{32'h1000_0000, 32'h8000_0001, 32'h0001_8000, 32'h7FFF_7FFF, 1'b1, 8'd0,
              16'h8000, 16'h0001, 16'h0001, 16'h8000, 16'h7FFF, 16'h7FFF};
    vs    = '{32'h1000_0003, 32'h0005_0006, 32'h0007_0008, 32'h0009_000A, 1'b1, 8'd3,
              16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    vb    = '{32'h1000_0008, 32'h0001_0001, 32'h0002_0002, 32'h0003_0003, 1'b0, 8'd8,
              16'd1, 16'd1, 16'd2, 16'd2, 16'd3, 16'd3};

    reset = 1'b1; stall = 1'b0; w_en = 1'b0;
    bus.tri_ready = 1'b1; bus.flush_done = 1'b0;
    drive_fifo();
    @(negedge clk); #1;
    cycle(); cycle();
    check("rst valid", bus.tri_valid, 1'b0);
    check("rst flush", bus.flush_start, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst err", err_illegal, 1'b0);
    check("rst frame", frame_count, 16'd0);
    check("rst read", bus.fifo_read, 1'b0);
    reset = 1'b0;
    settle();

    // Table of draw commands
    for (int i = 0; i < 3; i++) begin
      push_vec(vt[i]);
      settle();
      run_draw(vt[i], $sformatf("vec%0d", i));
    end

    // Rasterizer backpressure: hold for 5 cycles, handshake on the 6th
    push_vec(vt[0]); q.push_back(32'h0000_0000);
    bus.tri_ready = 1'b0;
    settle();
    pop4("bp");
    for (int k = 0; k < 5; k++) begin
      check_tri(vt[0], $sformatf("bp hold%0d", k));
      check($sformatf("bp nopop%0d", k), bus.fifo_read, 1'b0);
      cycle();
    end
    bus.tri_ready = 1'b1;
    settle();
    check_tri(vt[0], "bp hs");
    check("bp hs nopop", bus.fifo_read, 1'b0);
    cycle();
    check("bp drop", bus.tri_valid, 1'b0);
    check("bp nop pop", bus.fifo_read, 1'b1);
    cycle();
    check("bp nop gone", q.size(), 0);
    check("bp idle", busy, 1'b0);

    // FIFO runs dry after the first vertex
    q.push_back(vs.hdr); q.push_back(vs.w1);
    settle();
    check("st hdr pop", bus.fifo_read, 1'b1); cycle();
    check("st v1 pop", bus.fifo_read, 1'b1);  cycle();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("st hold%0d", k), bus.fifo_read, 1'b0);
      check($sformatf("st busy%0d", k), busy, 1'b1);
      cycle();
    end
    q.push_back(vs.w2); q.push_back(vs.w3);
    settle();
    check("st v2 pop", bus.fifo_read, 1'b1); cycle();
    check("st v3 pop", bus.fifo_read, 1'b1); cycle();
    check_tri(vs, "st");
    cycle();
    check("st drop", bus.tri_valid, 1'b0);

    // End of frame, done 7 cycles after the start pulse, then a draw
    q.push_back(32'h2FFF_FFFF); push_vec(vt[0]);
    settle();
    check("fl hdr pop", bus.fifo_read, 1'b1); cycle();
    check("fl start", bus.flush_start, 1'b1);
    check("fl busy", busy, 1'b1);
    check("fl nopop", bus.fifo_read, 1'b0);
    cycle();
    for (int k = 1; k < 7; k++) begin
      check($sformatf("fl pulse%0d", k), bus.flush_start, 1'b0);
      check($sformatf("fl wait%0d", k), bus.fifo_read, 1'b0);
      check($sformatf("fl cnt%0d", k), frame_count, 16'd0);
      cycle();
    end
    bus.flush_done = 1'b1;
    settle();
    check("fl done nopop", bus.fifo_read, 1'b0);
    cycle();
    bus.flush_done = 1'b0;
    settle();
    check("fl frame", frame_count, 16'd1);
    check("fl idle", busy, 1'b0);
    run_draw(vt[0], "fl draw");

    // Illegal opcode, out-of-range texture, then a good draw
    q.push_back(32'h9000_0000); push_vec(vb); push_vec(vt[1]);
    settle();
    check("il pop", bus.fifo_read, 1'b1);
    check("il err0", err_illegal, 1'b0);
    cycle();
    check("il err", err_illegal, 1'b1);
    check("il idle", busy, 1'b0);
    check("il q", q.size(), 8);
    run_draw(vb, "il badtex");
    run_draw(vt[1], "il good");
    check("il sticky", err_illegal, 1'b1);

    // Reset in the middle of a command
    push_vec(vt[2]);
    settle();
    cycle(); cycle();
    check("rm busy", busy, 1'b1);
    reset = 1'b1;
    settle();
    check("rm read", bus.fifo_read, 1'b0);
    cycle();
    check("rm valid", bus.tri_valid, 1'b0);
    check("rm busy0", busy, 1'b0);
    check("rm err", err_illegal, 1'b0);
    check("rm frame", frame_count, 16'd0);
    check("rm tex", bus.tri_tex, 8'd0);
    check("rm v1", {bus.tri_x1, bus.tri_y1}, 32'd0);
    check("rm v2", {bus.tri_x2, bus.tri_y2}, 32'd0);
    check("rm v3", {bus.tri_x3, bus.tri_y3}, 32'd0);
    check("rm fifo kept", q.size(), 2);
    q.delete();
    reset = 1'b0;
    settle();
    check("rm idle", busy, 1'b0);

    // Counter wrap on a 2-bit frame counter: one frame every 3 cycles
    w_en = 1'b1;
    #1;
    for (int s = 1; s <= 15; s++) begin
      cycle();
      if (s == 1)  check("wr start", wbus.flush_start, 1'b1);
      if (s == 3)  check("wr c1", w_frame, 2'd1);
      if (s == 6)  check("wr c2", w_frame, 2'd2);
      if (s == 9)  check("wr c3", w_frame, 2'd3);
      if (s == 12) check("wr c0", w_frame, 2'd0);
      if (s == 15) check("wr c1b", w_frame, 2'd1);
    end
    w_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
